// File: rtl/rsqrt_seed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsqrt_pkg
//  Description : Shared constants and the constant-table builder for the
//                1/sqrt(x) seed generator (signed Q16.16 operands).
//                - INT_BITS / FRAC_BITS : default operand format
//                - LUT_BITS             : mantissa bits used as LUT index
//                - RSQRT_SAT            : seed returned for x <= 0
//                - rsqrt_lut_entry()    : elaboration-time LUT entry value
//  Revision    : 1.0  initial release
// ============================================================================
package rsqrt_pkg;

    localparam int          INT_BITS  = 16;
    localparam int          FRAC_BITS = 16;
    localparam int          LUT_BITS  = 6;
    localparam logic [31:0] RSQRT_SAT = 32'h7FFF_FFFF;

    // Bit-serial integer square root (floor). Fixed trip count so it also
    // folds cleanly when evaluated at elaboration time.
    function automatic logic [63:0] isqrt64(input logic [63:0] v);
        logic [63:0] rem;
        logic [63:0] res;
        logic [63:0] b;
        rem = v;
        res = '0;
        b   = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (rem >= res + b) begin
                rem = rem - (res + b);
                res = (res >> 1) + b;
            end else begin
                res = res >> 1;
            end
            b = b >> 2;
        end
        return res;
    endfunction

    // Entry = round(2^frac_bits / sqrt(mid)) where mid is the bucket centre.
    //   even exponent: mid = 1 + (2j+1)/2^(L+1)  = N / 2^(L+1)
    //   odd  exponent: mid = 2 + (2j+1)/2^L      = N / 2^L
    //   with N = 2^(L+1) + 2j + 1.
    // round(sqrt(Q)) == (floor(sqrt(floor(4Q))) + 1) >> 1, which keeps the
    // whole computation in exact integer arithmetic.
    function automatic logic [31:0] rsqrt_lut_entry(
        input int unsigned idx,
        input int unsigned lut_bits  = LUT_BITS,
        input int unsigned frac_bits = FRAC_BITS
    );
        logic [63:0] n;
        logic [63:0] d;
        logic [63:0] q;
        logic [63:0] r;
        n = (64'd1 << (lut_bits + 1)) + 64'(2 * (idx % (32'd1 << lut_bits))) + 64'd1;
        d = ((idx >> lut_bits) != 0) ? (64'd1 << lut_bits) : (64'd1 << (lut_bits + 1));
        q = ((64'd1 << (2 * frac_bits + 2)) * d) / n;
        r = (isqrt64(q) + 64'd1) >> 1;
        return r[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsqrt_seed_if.sv
`default_nettype none
// ============================================================================
//  Module      : sfp_if
//  Description : Signed fixed-point operand bundle (Q INT_BITS.FRAC_BITS).
//                Ports: val [INT_BITS+FRAC_BITS-1:0] - two's complement value.
//                master drives val, slave reads it.
//  Revision    : 1.0  initial release
// ============================================================================
interface sfp_if #(
    parameter int INT_BITS  = rsqrt_pkg::INT_BITS,
    parameter int FRAC_BITS = rsqrt_pkg::FRAC_BITS
);
    logic [INT_BITS+FRAC_BITS-1:0] val;

    modport master (output val);
    modport slave  (input  val);
endinterface
`default_nettype wire

// File: rtl/rsqrt_seed_lzc32.sv
`default_nettype none
// ============================================================================
//  Module      : lzc32
//  Description : Combinational 32-bit leading-zero counter.
//                i_data  [31:0] : value to scan
//                o_count [5:0]  : number of leading zeros, 32 for all-zero
//  Revision    : 1.0  initial release
// ============================================================================
module lzc32 (
    input  wire logic [31:0] i_data,
    output logic      [5:0]  o_count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        o_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) begin
                o_count = 6'(31 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsqrt_seed.sv
`default_nettype none
// ============================================================================
//  Module      : rsqrt_seed
//  Description : 3-stage pipelined 1/sqrt(x) seed for signed Q16.16 input.
//                Normalise by leading-zero count, LUT on the mantissa,
//                denormalise by half the exponent. x <= 0 is flagged.
//  Ports       : clk      - clock, rising edge
//                resetn   - asynchronous active-low reset
//                start    - accept in.val this cycle (1 per cycle, no stall)
//                valid    - 1-cycle pulse, outputs belong to start 3 cycles ago
//                in       - sfp_if slave, operand x
//                x_out    - sfp_if master, x aligned with est
//                est      - sfp_if master, seed ~ 1/sqrt(x)
//                invalid  - x <= 0 for the item presented with valid
//  Revision    : 1.0  initial release
// ============================================================================
module rsqrt_seed #(
    parameter int INT_BITS  = rsqrt_pkg::INT_BITS,
    parameter int FRAC_BITS = rsqrt_pkg::FRAC_BITS,
    parameter int LUT_BITS  = rsqrt_pkg::LUT_BITS
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic start,
    output logic      valid,
    sfp_if.slave      in,
    sfp_if.master     x_out,
    sfp_if.master     est,
    output logic      invalid
);
    import rsqrt_pkg::*;

    localparam int W        = INT_BITS + FRAC_BITS;
    localparam int LUT_SIZE = 1 << (LUT_BITS + 1);

    // ------------------------------------------------------------------
    // Constant rsqrt table, built at elaboration
    // ------------------------------------------------------------------
    logic [31:0] w_lut [LUT_SIZE];

    generate
        for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
            localparam logic [31:0] ENTRY = rsqrt_lut_entry(gi, LUT_BITS, FRAC_BITS);
            assign w_lut[gi] = ENTRY;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [W-1:0]        x1_d,  x1_q;
    logic                v1_d,  v1_q;
    logic [W-1:0]        x2_d,  x2_q;
    logic [LUT_BITS:0]   idx2_d, idx2_q;
    logic signed [4:0]   h2_d,  h2_q;
    logic                neg2_d, neg2_q;
    logic                v2_d,  v2_q;
    logic [W-1:0]        xo_d,  xo_q;
    logic [31:0]         est_d, est_q;
    logic                inv_d, inv_q;
    logic                valid_d, valid_q;

    // ------------------------------------------------------------------
    // Stage 2 combinational: normalise
    // ------------------------------------------------------------------
    logic [5:0]          w_lz;
    logic signed [6:0]   w_k;
    logic [31:0]         w_norm;
    logic [LUT_BITS-1:0] w_frac;

    lzc32 u_lzc (
        .i_data  (x1_q),
        .o_count (w_lz)
    );

    always_comb begin
        // k = p - FRAC_BITS with p = 31 - lz
        w_k    = 7'(31 - FRAC_BITS) - $signed({1'b0, w_lz});
        // Shift the MSB up to bit 31; the bits beneath it are the LUT index
        // and short operands come out zero-filled for free.
        w_norm = x1_q << w_lz;
        w_frac = LUT_BITS'(w_norm >> (31 - LUT_BITS));
    end

    // ------------------------------------------------------------------
    // Stage 3 combinational: lookup and denormalise
    // ------------------------------------------------------------------
    logic [31:0] w_m;
    logic [4:0]  w_nh;
    logic [31:0] w_shifted;

    always_comb begin
        w_m  = w_lut[idx2_q];
        w_nh = $unsigned(-h2_q);
        // m is positive, so a logical right shift equals the arithmetic one
        if (!h2_q[4]) begin
            w_shifted = w_m >> h2_q[3:0];
        end else begin
            w_shifted = w_m << w_nh;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // stage 1
        v1_d   = start;
        x1_d   = start ? in.val : x1_q;

        // stage 2
        v2_d   = v1_q;
        x2_d   = x2_q;
        idx2_d = idx2_q;
        h2_d   = h2_q;
        neg2_d = neg2_q;
        if (v1_q) begin
            x2_d   = x1_q;
            // odd exponent selects the [2,4) half of the table
            idx2_d = {w_k[0], w_frac};
            h2_d   = 5'(w_k >>> 1);
            neg2_d = x1_q[W-1] | (x1_q == '0);
        end

        // stage 3: outputs hold while no item is presented
        valid_d = v2_q;
        xo_d    = xo_q;
        est_d   = est_q;
        inv_d   = inv_q;
        if (v2_q) begin
            xo_d  = x2_q;
            est_d = neg2_q ? RSQRT_SAT : w_shifted;
            inv_d = neg2_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x1_q    <= '0;
            v1_q    <= 1'b0;
            x2_q    <= '0;
            idx2_q  <= '0;
            h2_q    <= '0;
            neg2_q  <= 1'b0;
            v2_q    <= 1'b0;
            xo_q    <= '0;
            est_q   <= '0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            x1_q    <= x1_d;
            v1_q    <= v1_d;
            x2_q    <= x2_d;
            idx2_q  <= idx2_d;
            h2_q    <= h2_d;
            neg2_q  <= neg2_d;
            v2_q    <= v2_d;
            xo_q    <= xo_d;
            est_q   <= est_d;
            inv_q   <= inv_d;
            valid_q <= valid_d;
        end
    end

    assign valid     = valid_q;
    assign invalid   = inv_q;
    assign x_out.val = xo_q;
    assign est.val   = est_q;

endmodule
`default_nettype wire

// File: tb/tb_rsqrt_seed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsqrt_seed
//  Description : Self-checking bench for rsqrt_seed: directed vector table,
//                back-to-back burst and reset-in-flight sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rsqrt_seed;

    logic clk;
    logic resetn;
    logic start;
    logic valid;
    logic invalid;

    sfp_if #(16, 16) in_if ();
    sfp_if #(16, 16) xo_if ();
    sfp_if #(16, 16) est_if ();

    rsqrt_seed dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .valid   (valid),
        .in      (in_if),
        .x_out   (xo_if),
        .est     (est_if),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] x;
        bit          exact;   // 1: compare est bit-exact, 0: tolerance vs 1/sqrt
        logic [31:0] est;
        bit          inv;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Independent reference: est ~ 2^24 / sqrt(x_raw), allowed error 1/128 rel + 1 LSB
    task automatic chk_tol(input string name, input logic [31:0] x, input logic [31:0] act);
        real r, tol, diff;
        r    = 16777216.0 / $sqrt(real'(x));
        tol  = r / 128.0 + 1.0;
        diff = real'(act) - r;
        if (diff < 0.0) diff = -diff;
        n_total++;
        if (diff <= tol) n_pass++;
        else $display("FAIL %s: got %0d want %0.1f +/- %0.1f", name, act, r, tol);
    endtask

    // Issue one operand, wait (bounded) for valid; ends at the negedge of the valid cycle.
    task automatic run_one(input logic [31:0] x, output int lat, output bit found);
        @(posedge clk); #1;
        start     = 1'b1;
        in_if.val = x;
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 8) begin
            @(negedge clk);
            if (valid) found = 1'b1;
            else begin
                lat++;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int          lat;
        bit          found;
        logic [31:0] xs [8];
        int          got;
        int          bad_valid;

        vecs[0]  = '{32'h0001_0000, 1'b1, 32'h0000_FF01, 1'b0};  // 1.0
        vecs[1]  = '{32'h0004_0000, 1'b1, 32'h0000_7F80, 1'b0};  // 4.0
        vecs[2]  = '{32'h0000_0001, 1'b1, 32'h00FF_0100, 1'b0};  // min positive
        vecs[3]  = '{32'h7FFF_FFFF, 1'b0, 32'h0,         1'b0};  // max positive
        vecs[4]  = '{32'h0002_0000, 1'b0, 32'h0,         1'b0};  // odd exponent
        vecs[5]  = '{32'h0000_8000, 1'b0, 32'h0,         1'b0};  // negative h, odd
        vecs[6]  = '{32'h0003_0000, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};  // zero
        vecs[9]  = '{32'hFFFF_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};  // -1.0
        vecs[10] = '{32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};  // most negative

        resetn    = 1'b0;
        start     = 1'b0;
        in_if.val = '0;
        repeat (3) @(posedge clk);
        // start while in reset must be ignored
        #1; start = 1'b1; in_if.val = 32'h0001_0000;
        @(negedge clk);
        chk("reset_valid",   {31'd0, valid},   32'd0);
        chk("reset_invalid", {31'd0, invalid}, 32'd0);
        chk("reset_est",     est_if.val,       32'd0);
        chk("reset_x_out",   xo_if.val,        32'd0);
        @(posedge clk); #1;
        start  = 1'b0;
        resetn = 1'b1;

        // ---------------- directed vectors ----------------
        for (int i = 0; i < 11; i++) begin
            run_one(vecs[i].x, lat, found);
            if (!found) begin
                n_total++;
                $display("FAIL vec%0d_timeout: got no valid want valid at +3", i);
            end else begin
                chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
                chk($sformatf("vec%0d_x_out", i), xo_if.val, vecs[i].x);
                chk($sformatf("vec%0d_invalid", i), {31'd0, invalid}, {31'd0, vecs[i].inv});
                if (vecs[i].exact) chk($sformatf("vec%0d_est", i), est_if.val, vecs[i].est);
                else               chk_tol($sformatf("vec%0d_est", i), vecs[i].x, est_if.val);
                @(negedge clk);
                chk($sformatf("vec%0d_pulse", i), {31'd0, valid}, 32'd0);
            end
        end

        // ---------------- back-to-back burst ----------------
        for (int i = 0; i < 8; i++) xs[i] = ($urandom() & 32'h7FFF_FFFF) | 32'h1;
        got = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c < 8) begin start = 1'b1; in_if.val = xs[c]; end
            else start = 1'b0;
            @(negedge clk);
            if (valid) begin
                if (got < 8) begin
                    chk($sformatf("burst%0d_cycle", got), 32'(c), 32'(got + 3));
                    chk($sformatf("burst%0d_x_out", got), xo_if.val, xs[got]);
                    chk($sformatf("burst%0d_invalid", got), {31'd0, invalid}, 32'd0);
                    chk_tol($sformatf("burst%0d_est", got), xs[got], est_if.val);
                end
                got++;
            end
        end
        chk("burst_count", 32'(got), 32'd8);

        // ---------------- reset with items in flight ----------------
        @(posedge clk); #1; start = 1'b1; in_if.val = 32'h0009_0000;
        @(posedge clk); #1; in_if.val = 32'h0010_0000;
        @(posedge clk); #1; start = 1'b0; resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        bad_valid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid) bad_valid++;
        end
        chk("flush_no_valid", 32'(bad_valid), 32'd0);
        chk("flush_est",      est_if.val,     32'd0);
        chk("flush_x_out",    xo_if.val,      32'd0);
        chk("flush_invalid",  {31'd0, invalid}, 32'd0);

        run_one(32'h0001_0000, lat, found);
        if (!found) begin
            n_total++;
            $display("FAIL post_reset_timeout: got no valid want valid at +3");
        end else begin
            chk("post_reset_latency", 32'(lat), 32'd3);
            chk("post_reset_est", est_if.val, 32'h0000_FF01);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
